// File: rtl/rate_div_pkg.sv
// rate_div_pkg: shared constants and types for the multi-rate divider
package rate_div_pkg;
  localparam int CNT_W_DEF = 26;
  localparam int DIV_1HZ = 49_999_999;
  localparam int DIV_SCAN = 49_999;
  typedef enum logic {MODE_TOGGLE, MODE_PULSE} mode_e;
  typedef enum logic {CFG_IDLE, CFG_PENDING} cfg_state_e;
endpackage

// File: rtl/rate_div_channel.sv
// rate_div_channel: one programmable counter producing tick and toggle/pulse output
module rate_div_channel import rate_div_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DIV_RESET = CNT_W'(DIV_1HZ)
) (
  input  logic             masterclk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             restart,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             term,
  output logic             tick,
  output logic             clk_out
);
  logic [CNT_W-1:0] cnt, div_reg;
  logic mode_r;
  // >= so a shrunk divisor below the running count still ends the period once
  assign term = en && (cnt >= div_reg);
  always_ff @(posedge masterclk) begin
    if (!rst_n) begin
      cnt <= '0;
      div_reg <= DIV_RESET;
      tick <= 1'b0;
      clk_out <= 1'b0;
      mode_r <= MODE_TOGGLE;
    end else begin
      if (load) div_reg <= load_val;
      if (restart || !en) begin
        cnt <= '0;
        tick <= 1'b0;
        clk_out <= 1'b0;
        mode_r <= mode;
      end else if (term) begin
        cnt <= '0;
        tick <= 1'b1;
        clk_out <= (mode == MODE_PULSE) ? 1'b1 : ~clk_out;
        mode_r <= mode;
      end else begin
        cnt <= cnt + 1'b1;
        tick <= 1'b0;
        clk_out <= (mode_r == MODE_PULSE) ? 1'b0 : clk_out;
      end
    end
  end
endmodule

// File: rtl/multi_rate_divider.sv
// multi_rate_divider: NUM_CH programmable dividers sharing one valid/ready divisor update port
module multi_rate_divider import rate_div_pkg::*; #(
  parameter int NUM_CH = 2,
  parameter int CNT_W = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DIV_RESET = CNT_W'(DIV_1HZ),
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              masterclk,
  input  logic              rst_n,
  input  logic              sync_restart,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] ch_mode,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
);
  cfg_state_e state, state_n;
  logic [CH_W-1:0] sh_ch;
  logic [CNT_W-1:0] sh_div;
  logic [NUM_CH-1:0] sel, term, load;
  logic accept, apply, ch_ok;
  assign ch_ok = {1'b0, cfg_ch} < (CH_W+1)'(NUM_CH);
  always_ff @(posedge masterclk) begin
    if (!rst_n) begin
      state <= CFG_IDLE;
      cfg_ready <= 1'b1;
      sh_ch <= '0;
      sh_div <= '0;
    end else begin
      state <= state_n;
      cfg_ready <= (state_n == CFG_IDLE);
      if (accept && ch_ok) begin
        sh_ch <= cfg_ch;
        sh_div <= cfg_div;
      end
    end
  end
  // restart takes the cycle, so a request arriving with it waits
  always_comb begin
    accept = cfg_valid && cfg_ready && !sync_restart;
    apply = sync_restart || !(|(ch_en & sel)) || |(term & sel);
    state_n = (state == CFG_IDLE) ? ((accept && ch_ok) ? CFG_PENDING : CFG_IDLE)
                                  : (apply ? CFG_IDLE : CFG_PENDING);
    load = (state == CFG_PENDING && apply) ? sel : '0;
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign sel[i] = (sh_ch == CH_W'(i));
    rate_div_channel #(.CNT_W(CNT_W), .DIV_RESET(DIV_RESET)) u_ch (
      .masterclk(masterclk),
      .rst_n(rst_n),
      .en(ch_en[i]),
      .mode(ch_mode[i]),
      .restart(sync_restart),
      .load(load[i]),
      .load_val(sh_div),
      .term(term[i]),
      .tick(tick[i]),
      .clk_out(clk_out[i])
    );
  end
endmodule

// File: tb/tb_multi_rate_divider.sv
// tb_multi_rate_divider: directed literal checks plus randomized run against a time-based model
module tb_multi_rate_divider;
  localparam int N = 3;
  localparam int DR = 3;
  logic masterclk = 1'b0;
  logic rst_n, sync_restart, cfg_valid, cfg_ready;
  logic [N-1:0] ch_en, ch_mode, tick, clk_out;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  int checks = 0, failures = 0, cyc = 0;
  int m_start[N], m_div[N];
  bit m_amode[N];
  bit [N-1:0] m_tick, m_clk;
  bit m_pend;
  int m_pch, m_pdiv;

  multi_rate_divider #(.NUM_CH(N), .CNT_W(8), .DIV_RESET(8'(DR))) dut (
    .masterclk(masterclk), .rst_n(rst_n), .sync_restart(sync_restart),
    .ch_en(ch_en), .ch_mode(ch_mode), .cfg_valid(cfg_valid), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_ready(cfg_ready), .tick(tick), .clk_out(clk_out)
  );

  always #5 masterclk = ~masterclk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  // Model: each channel remembers the cycle its current period began; it ends once
  // the elapsed cycles reach the divisor.
  task automatic model_step();
    bit [N-1:0] term;
    bit apply;
    if (!rst_n) begin
      for (int c = 0; c < N; c++) begin
        m_start[c] = cyc + 1; m_div[c] = DR; m_amode[c] = 0;
      end
      m_tick = '0; m_clk = '0; m_pend = 0;
    end else begin
      for (int c = 0; c < N; c++) term[c] = ch_en[c] && (cyc - m_start[c]) >= m_div[c];
      apply = m_pend && (sync_restart || !ch_en[m_pch] || term[m_pch]);
      for (int c = 0; c < N; c++) begin
        if (sync_restart || !ch_en[c]) begin
          m_start[c] = cyc + 1; m_tick[c] = 0; m_clk[c] = 0; m_amode[c] = ch_mode[c];
        end else if (term[c]) begin
          m_start[c] = cyc + 1; m_tick[c] = 1; m_amode[c] = ch_mode[c];
          m_clk[c] = ch_mode[c] ? 1'b1 : !m_clk[c];
        end else begin
          m_tick[c] = 0;
          if (m_amode[c]) m_clk[c] = 0;
        end
      end
      if (apply) begin
        m_div[m_pch] = m_pdiv; m_pend = 0;
      end else if (!m_pend && cfg_valid && !sync_restart && cfg_ch < N) begin
        m_pend = 1; m_pch = cfg_ch; m_pdiv = cfg_div;
      end
    end
    cyc++;
  endtask

  task automatic run1();
    model_step();
    @(negedge masterclk);
    chk("tick", tick, m_tick);
    chk("clk_out", clk_out, m_clk);
    chk("cfg_ready", cfg_ready, !m_pend);
  endtask

  task automatic runn(int n);
    for (int i = 0; i < n; i++) run1();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] exp_t, exp_c;
    bit found;
    rst_n = 0; sync_restart = 0; ch_en = '1; ch_mode = '0;
    cfg_valid = 0; cfg_ch = 0; cfg_div = 0;
    runn(2);
    chk("rst_tick", tick, 0);
    chk("rst_clk", clk_out, 0);
    chk("rst_ready", cfg_ready, 1);
    // power-up period: ticks at 4,8,12; square wave high over 4..7 and from 12
    rst_n = 1;
    exp_t = 12'b1000_1000_1000;
    exp_c = 12'b1000_0111_1000;
    for (int n = 1; n <= 12; n++) begin
      run1();
      chk("t1_tick", tick[0], exp_t[n-1]);
      chk("t1_clk", clk_out[0], exp_c[n-1]);
    end
    // divisor change mid-period: old period completes at 16, then every 2 cycles
    run1();
    cfg_valid = 1; cfg_ch = 0; cfg_div = 1;
    run1();
    cfg_valid = 0;
    chk("t2_ready_lo", cfg_ready, 0);
    run1();
    chk("t2_tick15", tick[0], 0);
    chk("t2_ready15", cfg_ready, 0);
    run1();
    chk("t2_tick16", tick[0], 1);
    chk("t2_ready16", cfg_ready, 1);
    for (int n = 17; n <= 22; n++) begin
      run1();
      chk("t2_tick", tick[0], n % 2 == 0);
    end
    // pulse mode with D=0
    ch_mode = 3'b001; cfg_valid = 1; cfg_ch = 0; cfg_div = 0;
    run1();
    cfg_valid = 0;
    runn(4);
    for (int n = 0; n < 3; n++) begin
      run1();
      chk("t3_tick", tick[0], 1);
      chk("t3_clk", clk_out[0], 1);
    end
    ch_en = 3'b110;
    run1();
    chk("t3_off_tick", tick[0], 0);
    chk("t3_off_clk", clk_out[0], 0);
    ch_en = 3'b111;
    run1();
    chk("t3_reen_tick", tick[0], 1);
    // update to disabled channel, then invalid channel
    ch_mode = '0; ch_en = 3'b101;
    run1();
    cfg_valid = 1; cfg_ch = 1; cfg_div = 7;
    run1();
    cfg_valid = 0;
    chk("t4_ready_lo", cfg_ready, 0);
    run1();
    chk("t4_ready_hi", cfg_ready, 1);
    cfg_valid = 1; cfg_ch = 3; cfg_div = 5;
    run1();
    cfg_valid = 0;
    chk("t4_invalid_ready", cfg_ready, 1);
    ch_en = 3'b111;
    for (int n = 1; n <= 8; n++) begin
      run1();
      chk("t4_ch1_tick", tick[1], n == 8);
    end
    // restart with a pending update: ch1 (now D=3) and ch2 (D=3) tick together
    cfg_valid = 1; cfg_ch = 1; cfg_div = 3;
    run1();
    cfg_valid = 0; sync_restart = 1;
    run1();
    sync_restart = 0;
    chk("t5_tick", tick, 0);
    chk("t5_clk", clk_out, 0);
    chk("t5_ready", cfg_ready, 1);
    for (int n = 1; n <= 4; n++) begin
      run1();
      chk("t5_tick12", tick[2:1], (n == 4) ? 2'b11 : 2'b00);
    end
    // reset during pending while clk_out is high
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      run1();
      found = clk_out[2];
    end
    chk("t6_found_high", found, 1);
    cfg_valid = 1; cfg_ch = 2; cfg_div = 9;
    run1();
    cfg_valid = 0;
    chk("t6_pending", cfg_ready, 0);
    chk("t6_clk_hi", clk_out[2], 1);
    rst_n = 0;
    run1();
    rst_n = 1;
    chk("t6_tick", tick, 0);
    chk("t6_clk", clk_out, 0);
    chk("t6_ready", cfg_ready, 1);
    for (int n = 1; n <= 4; n++) begin
      run1();
      chk("t6_div_reset", tick, (n == 4) ? 3'b111 : 3'b000);
    end
    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      sync_restart = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 29) == 0) ch_en = 3'($urandom);
      if ($urandom_range(0, 39) == 0) ch_mode = 3'($urandom);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch = 2'($urandom);
      cfg_div = 8'($urandom_range(0, 9));
      run1();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
